or_approx_seq_mult: RTL

OR_APPROX_SEQ_MULT -- requirements
Module: or_approx_seq_mult

---
 rtl/or_approx_seq_mult.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/or_approx_seq_mult.sv
// Sequential nibble-serial unsigned multiplier: one 4x4 sub-product per cycle,
// each either exact or OR-approximate, summed exactly into a 2N-bit accumulator.
module or_approx_seq_mult #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           mode,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*N-1:0] Y,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int NN = N / 4;
    localparam int K  = NN * NN;
    localparam int CW = $clog2(K) + 1;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] mul4_exact(input logic [3:0] x, input logic [3:0] y);
        return 8'(x) * 8'(y);
    endfunction

    // 2x2 partial products merged with OR instead of addition
    function automatic logic [7:0] mul4_or(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] hh, hl, lh, ll;
        hh = 4'(x[3:2]) * 4'(y[3:2]);
        hl = 4'(x[3:2]) * 4'(y[1:0]);
        lh = 4'(x[1:0]) * 4'(y[3:2]);
        ll = 4'(x[1:0]) * 4'(y[1:0]);
        return {hh, 4'b0000} | {2'b00, hl, 2'b00} | {2'b00, lh, 2'b00} | {4'b0000, ll};
    endfunction

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d;
    logic             mode_q, mode_d;
    logic [2*N-1:0]   acc_q, acc_d, y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    i_q, i_d, j_q, j_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [3:0]       a_nib_s, b_nib_s;
    logic [7:0]       m_s;
    logic [2*N-1:0]   sp_s, sum_s;

    // Current sub-product (i inner, j outer) and running sum
    always_comb begin
        a_nib_s = a_q[4*i_q +: 4];
        b_nib_s = b_q[4*j_q +: 4];
        if (mode_q) begin
            m_s = mul4_or(a_nib_s, b_nib_s);
        end else begin
            m_s = mul4_exact(a_nib_s, b_nib_s);
        end
        sp_s  = (2*N)'(m_s) << (4 * (int'(i_q) + int'(j_q)));
        sum_s = acc_q + sp_s;
    end

    // Next-state logic for the IDLE/CALC/DONE handshake FSM
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        i_d      = i_q;
        j_d      = j_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    acc_d   = {(2*N){1'b0}};
                    cnt_d   = {CW{1'b0}};
                    i_d     = {IW{1'b0}};
                    j_d     = {IW{1'b0}};
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d = sum_s;
                cnt_d = cnt_q + CW'(1);
                if (i_q == IW'(NN - 1)) begin
                    i_d = {IW{1'b0}};
                    j_d = j_q + IW'(1);
                end else begin
                    i_d = i_q + IW'(1);
                end
                if (cnt_q == CW'(K - 1)) begin
                    y_d     = sum_s;
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= {N{1'b0}};
            b_q         <= {N{1'b0}};
            mode_q      <= 1'b0;
            acc_q       <= {(2*N){1'b0}};
            y_q         <= {(2*N){1'b0}};
            cnt_q       <= {CW{1'b0}};
            i_q         <= {IW{1'b0}};
            j_q         <= {IW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            i_q         <= i_d;
            j_q         <= j_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Y         = y_q;

endmodule
